// File: rtl/cam_ram_rn_rw1_clr_if.sv
// Bus bundle for cam_ram_rn_rw1_clr.
//   flush       : one-cycle request to re-clear the RAM
//   init_done   : RAM cleared, accesses accepted
//   wr_*        : read-write port (enable, address, data, byte enables)
//   wr_data_out : pre-write contents at wr_addr
//   rd_enb/addr : per-port read strobes and packed addresses (port p at [p*A +: A])
//   rd_data/vld : per-port packed read data (port p at [p*D +: D]) and valid pulses
interface cam_ram_rn_rw1_clr_if #(
    parameter int A  = 9,
    parameter int D  = 64,
    parameter int NR = 2
);
    logic              flush;
    logic              init_done;
    logic              wr_enb;
    logic [A-1:0]      wr_addr;
    logic [D-1:0]      wr_data;
    logic [D/8-1:0]    wr_be;
    logic [D-1:0]      wr_data_out;
    logic [NR-1:0]     rd_enb;
    logic [NR*A-1:0]   rd_addr;
    logic [NR*D-1:0]   rd_data;
    logic [NR-1:0]     rd_vld;

    modport master (
        output flush, wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
        input  init_done, wr_data_out, rd_data, rd_vld
    );

    modport slave (
        input  flush, wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
        output init_done, wr_data_out, rd_data, rd_vld
    );
endinterface

// File: rtl/cam_ram_rn_rw1_clr.sv
// RAM with one read-write port (byte enables, read-first old-data output)
// and NR read-only ports, self-clearing after reset or flush.
//   clk : single clock, posedge
//   rst : asynchronous active-high reset
//   bus : cam_ram_rn_rw1_clr_if slave (see interface header)
// Read latency L = 1 + OREG for both rd_data and wr_data_out.
module cam_ram_rn_rw1_clr #(
    parameter int A    = 9,
    parameter int D    = 64,
    parameter int NR   = 2,
    parameter int BYP  = 1,
    parameter int OREG = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    cam_ram_rn_rw1_clr_if.slave  bus
);
    localparam int NB    = D / 8;
    localparam int DEPTH = 1 << A;

    typedef enum logic {CLEAR, READY} state_t;

    state_t         state, state_nxt;
    logic [A-1:0]   cnt;
    logic           ready;
    logic [D-1:0]   mem [DEPTH];
    logic [D-1:0]   wr_old, wr_merged;

    // first pipeline stage (registered RAM read)
    logic [NR-1:0][D-1:0] rd1;
    logic [NR-1:0]        vld1;
    logic [D-1:0]         wo1;
    logic                 wo_v1;

    assign ready         = (state == READY);
    assign bus.init_done = ready;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // counter walks only while clearing; parked at 0 otherwise so a
            // flush restarts from address 0
            cnt   <= (state == CLEAR) ? A'(cnt + 1'b1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (cnt == {A{1'b1}}) state_nxt = READY;
            READY: if (bus.flush)        state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // ---------------- write port ----------------
    assign wr_old = mem[bus.wr_addr];

    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < NB; i++)
            if (bus.wr_be[i]) wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end

    // RAM array is deliberately not reset; CLEAR zeroes it one word per cycle
    always_ff @(posedge clk) begin
        if (!ready)          mem[cnt]         <= '0;
        else if (bus.wr_enb) mem[bus.wr_addr] <= wr_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wo1   <= '0;
            wo_v1 <= 1'b0;
        end else begin
            wo_v1 <= ready;
            if (ready) wo1 <= wr_old;
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < NR; p++) begin : g_rd
        logic [A-1:0] ra;
        logic         hit;
        assign ra  = bus.rd_addr[p*A +: A];
        // same-cycle write to the same word: forward the merged word
        assign hit = (BYP != 0) && bus.wr_enb && (ra == bus.wr_addr);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd1[p]  <= '0;
                vld1[p] <= 1'b0;
            end else begin
                vld1[p] <= ready & bus.rd_enb[p];
                if (ready && bus.rd_enb[p]) rd1[p] <= hit ? wr_merged : mem[ra];
            end
        end
    end

    // ---------------- optional output stage ----------------
    if (OREG != 0) begin : g_oreg
        logic [NR-1:0][D-1:0] rd2;
        logic [NR-1:0]        vld2;
        logic [D-1:0]         wo2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd2  <= '0;
                vld2 <= '0;
                wo2  <= '0;
            end else begin
                vld2 <= vld1;
                if (wo_v1) wo2 <= wo1;
                for (int p = 0; p < NR; p++)
                    if (vld1[p]) rd2[p] <= rd1[p];
            end
        end

        assign bus.rd_data     = rd2;
        assign bus.rd_vld      = vld2;
        assign bus.wr_data_out = wo2;
    end else begin : g_noreg
        assign bus.rd_data     = rd1;
        assign bus.rd_vld      = vld1;
        assign bus.wr_data_out = wo1;
    end
endmodule

// File: doc/cam_ram_rn_rw1_clr.md
CAM_RAM_RN_RW1_CLR -- requirements
Module: cam_ram_rn_rw1_clr

Interface
REQ-001 SHALL have parameter A, default 9, the number of address bits (depth 2^A).
REQ-002 SHALL have parameter D, default 64, the number of data bits; D SHALL be a multiple of 8.
REQ-003 SHALL have parameter NR, default 2, the number of independent read-only ports.
REQ-004 SHALL have parameter BYP, default 1; 1 = write-to-read forwarding, 0 = read-old-data.
REQ-005 SHALL have parameter OREG, default 0; 1 = one extra output register stage on all read data.
REQ-006 Clk  in  1  single clock; all logic is on the posedge.
REQ-007 Rst  in  1  asynchronous, active-high reset.
REQ-008 Flush  in  1  one-cycle request to re-clear the whole RAM.
REQ-009 InitDone  out  1  RAM cleared and accepting accesses.
REQ-010 WrEnb  in  1  write strobe for the RW port.
REQ-011 WrAddr  in  A  RW port address.
REQ-012 WrData  in  D  write data.
REQ-013 WrBe  in  D/8  byte enables; bit i covers WrData[8i+7:8i].
REQ-014 WrDataOut  out  D  pre-write (old) contents at WrAddr.
REQ-015 RdEnb  in  NR  per-port read strobe.
REQ-016 RdAddr  in  NR*A  port p address at bits [p*A +: A].
REQ-017 RdData  out  NR*D  port p data at bits [p*D +: D].
REQ-018 RdVld  out  NR  per-port read-data-valid pulse.

Function
REQ-019 SHALL implement a clear FSM with states CLEAR and READY.
REQ-020 In CLEAR, a counter SHALL write 0 to addresses 0 .. 2^A-1, one address per cycle.
REQ-021 CLEAR SHALL go to READY on the cycle after address 2^A-1 is written; InitDone SHALL be registered high in READY.
REQ-022 Flush sampled high in READY SHALL drop InitDone next cycle, reset the counter to 0 and enter CLEAR.
REQ-023 Flush sampled high while in CLEAR SHALL be ignored.
REQ-024 In CLEAR, WrEnb and RdEnb SHALL be ignored, RdVld SHALL stay 0 and WrDataOut SHALL hold.
REQ-025 In READY, with WrEnb=1, byte i of RAM[WrAddr] SHALL take WrData byte i only where WrBe[i]=1; other bytes keep their value.
REQ-026 WrEnb=1 with WrBe all zero SHALL leave RAM unchanged but still update WrDataOut.
REQ-027 WrDataOut SHALL be read-first: it returns RAM[WrAddr] before the write, with latency L = 1+OREG; it updates every READY cycle, regardless of WrEnb.
REQ-028 RdEnb[p]=1 in READY SHALL produce RdData port p and RdVld[p]=1 exactly L cycles later; RdVld SHALL be a single-cycle pulse per request.
REQ-029 RdData port p SHALL hold its last value when RdEnb[p]=0.
REQ-030 With the same read and write address in the same cycle: BYP=1 SHALL return the byte-merged new word (enabled bytes new, others old); BYP=0 SHALL return the old word.
REQ-031 Several read ports at one address SHALL all return identical data.
REQ-032 Back-to-back reads SHALL be fully pipelined, one per port per cycle, with no stalls.
REQ-033 Addresses are used modulo 2^A; no out-of-range checking.

Reset
REQ-034 Rst high SHALL immediately force InitDone=0, RdVld=0, RdData=0, WrDataOut=0, counter=0, state=CLEAR.
REQ-035 Rst asserted mid-CLEAR or mid-pipeline SHALL discard in-flight reads (no RdVld) and restart clearing from address 0 after Rst deasserts.
REQ-036 RAM contents are not reset directly; they are zero only after CLEAR completes.

Verification
REQ-037 Release Rst with A=4 -> InitDone rises after 16 clear cycles (the cycle after address 15 is written); a read of every address then returns 0.
REQ-038 In READY, write 0x1122334455667788 to address 3 with WrBe=0xFF, then write 0xAAAA... to address 3 with WrBe=0x0F -> a read of address 3 returns 0x11223344AAAAAAAA; the second write's WrDataOut is 0x1122334455667788.
REQ-039 Write address 5 = 0xDEAD (full WrBe) while port 0 and port 1 both read address 5 in the same cycle -> with BYP=1 both return 0xDEAD after L cycles; with BYP=0 both return the prior value 0.
REQ-040 With OREG=1, drive RdEnb[0] on 3 consecutive cycles at addresses 1, 2, 3 -> RdVld[0] pulses on 3 consecutive cycles, starting 2 cycles after the first request, with matching data in order.
REQ-041 Pulse Flush in READY after filling the RAM -> InitDone falls, writes and reads issued during CLEAR are ignored (RdVld=0), and after 2^A cycles all addresses read 0.
REQ-042 Assert Rst at clear counter value 7, hold 2 cycles, then release -> all outputs are 0 and clearing restarts at address 0, taking a full 2^A cycles to reach InitDone=1.
